pea_invoke_scheduler: RTL

- Sequences firings of the PEA actor (PEA_top_module_1 plus PEA_enable) without testbench hand-driving.
- Drives next_instr and a one-cycle invoke pulse, waits for firing-complete (FC), then latches the actor's next CFDF mode.
- Repeats until stopped, a firing limit is reached, or an error occurs.
- Sits between the system controller and the PEA actor; replaces the manual enable/invoke/wait(FC) sequence.

---
 rtl/pea_sched_pkg.sv | 30 +++
 rtl/pea_sched_watchdog.sv | 29 ++
 rtl/pea_invoke_scheduler.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pea_sched_pkg.sv
// Shared definitions for the PEA invoke scheduler: CFDF mode codes,
// FSM state encoding and a ceiling-log2 helper.
package pea_sched_pkg;

    localparam logic [1:0] SETUP_INSTR  = 2'b00;
    localparam logic [1:0] INSTR        = 2'b01;
    localparam logic [1:0] OUTPUT       = 2'b10;
    localparam logic [1:0] MODE_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        CHECK   = 3'd2,
        INVOKE  = 3'd3,
        WAIT_FC = 3'd4,
        DONE    = 3'd5,
        ERR     = 3'd6
    } state_t;

    // Ceiling log2, never less than one bit wide.
    function automatic int log2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pea_sched_watchdog.sv
// WAIT_FC watchdog: counts idle cycles while waiting for firing-complete
// and trips when the count reaches TMO_CYC.
module pea_sched_watchdog
    import pea_sched_pkg::*;
#(
    parameter int TMO_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic trip
);

    localparam int W = log2(TMO_CYC + 1);

    logic [W-1:0] cnt;

    // Cycle counter, cleared whenever the scheduler is outside WAIT_FC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      cnt <= '0;
        else if (clr)  cnt <= '0;
        else if (inc)  cnt <= cnt + 1'b1;
    end

    // Trip on the increment that brings the count to TMO_CYC.
    assign trip = inc && (cnt == W'(TMO_CYC - 1));

endmodule

// File: rtl/pea_invoke_scheduler.sv
// Firing sequencer for the PEA actor: present mode, wait for enable,
// pulse invoke, wait for FC, latch next mode. Option: PEA_SCHED_WATCHDOG_EN.
module pea_invoke_scheduler
    import pea_sched_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TMO_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] fire_limit,
    input  logic             enable_in,
    input  logic             fc_in,
    input  logic [1:0]       next_mode_in,
    output logic             invoke_out,
    output logic [1:0]       next_instr_out,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] fire_count
`ifdef PEA_SCHED_WATCHDOG_EN
    ,
    output logic             watchdog_trip
`endif
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] limit;
    logic [CNT_W-1:0] count_inc;
    logic             fc_ok;
    logic             limit_hit;
    logic             wd_hit;

    assign count_inc = fire_count + 1'b1;
    assign fc_ok     = (state == WAIT_FC) && fc_in &&
                       (next_mode_in != MODE_ILLEGAL);
    assign limit_hit = (limit != '0) && (count_inc == limit);

`ifdef PEA_SCHED_WATCHDOG_EN
    logic wd_trip_q;

    pea_sched_watchdog #(
        .TMO_CYC (TMO_CYC)
    ) u_wd (
        .clk  (clk),
        .rst  (rst),
        .clr  (state != WAIT_FC),
        .inc  ((state == WAIT_FC) && !fc_in),
        .trip (wd_hit)
    );

    // Sticky cause flag, set only when the watchdog forces ERR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        wd_trip_q <= 1'b0;
        else if (wd_hit) wd_trip_q <= 1'b1;
    end

    assign watchdog_trip = wd_trip_q;
`else
    localparam int tmo_unused = TMO_CYC;
    assign wd_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_nxt  = state;
        invoke_out = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = SETTLE;
            end
            SETTLE: state_nxt = CHECK;
            CHECK: begin
                if (!start)         state_nxt = IDLE;
                else if (enable_in) state_nxt = INVOKE;
            end
            INVOKE: begin
                invoke_out = 1'b1;
                state_nxt  = WAIT_FC;
            end
            WAIT_FC: begin
                if (fc_in) begin
                    if (next_mode_in == MODE_ILLEGAL) state_nxt = ERR;
                    else if (limit_hit)               state_nxt = DONE;
                    else                              state_nxt = SETTLE;
                end else if (wd_hit) begin
                    state_nxt = ERR;
                end
            end
            DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (!start) state_nxt = IDLE;
            end
            ERR: begin
                busy  = 1'b0;
                error = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Mode latch, firing counter and limit capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            next_instr_out <= SETUP_INSTR;
            fire_count     <= '0;
            limit          <= '0;
        end else begin
            if (state == IDLE && start) begin
                fire_count <= '0;
                limit      <= fire_limit;
            end
            if (fc_ok) begin
                next_instr_out <= next_mode_in;
                fire_count     <= count_inc;
            end
            if (state_nxt == IDLE && state != IDLE) begin
                next_instr_out <= SETUP_INSTR;
            end
        end
    end

endmodule
